// File: rtl/ram_banked.sv
// Byte-lane simple dual-port RAM with write-first forwarding, selectable read
// latency, out-of-range flagging and a hardware clear sweep.
module ram_banked #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LANE_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned OUT_REG     = 0,
  parameter int unsigned INIT_CLEAR  = 1,
  localparam int unsigned NUM_LANES  = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_LANES-1:0]  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  rd_err_o,
  output logic                  wr_err_o,
  input  logic                  clear_i,
  output logic                  busy_o
);

  localparam int unsigned ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned WORD_W   = ADDR_WIDTH - ADDR_LSB;
  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic                  rd_a_valid_q, rd_a_valid_d;
  logic                  rd_a_err_q, rd_a_err_d;
  logic [DATA_WIDTH-1:0] rd_a_data_q, rd_a_data_d;
  logic                  wr_err_q, wr_err_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [WORD_W-1:0]     wr_word, rd_word;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_oor, rd_oor, idle, wr_hit, rd_fire;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [NUM_LANES-1:0]  mem_lane_en;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rd_fwd;

  // Word decode and range check; the byte offset bits select nothing.
  always_comb begin
    wr_word = wr_addr_i[ADDR_WIDTH-1:ADDR_LSB];
    rd_word = rd_addr_i[ADDR_WIDTH-1:ADDR_LSB];
    wr_idx  = wr_word[IDX_W-1:0];
    rd_idx  = rd_word[IDX_W-1:0];
    wr_oor  = 64'(wr_word) >= 64'(DEPTH_WORDS);
    rd_oor  = 64'(rd_word) >= 64'(DEPTH_WORDS);
    idle    = (state_q == ST_IDLE);
    wr_hit  = idle && (|wr_en_i) && !wr_oor;
    rd_fire = idle && rd_en_i;
  end

  if (ADDR_LSB > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^{wr_addr_i[ADDR_LSB-1:0], rd_addr_i[ADDR_LSB-1:0]};
  end

  // Sweep FSM and array write-port mux.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    mem_we      = 1'b0;
    mem_idx     = wr_idx;
    mem_lane_en = wr_en_i;
    mem_wdata   = wr_data_i;
    case (state_q)
      ST_CLEAR: begin
        mem_we      = 1'b1;
        mem_idx     = clr_cnt_q;
        mem_lane_en = '1;
        mem_wdata   = '0;
        if (clr_cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        mem_we = wr_hit;
        if (clear_i) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write-first merge: lanes being written this cycle bypass the array.
  always_comb begin
    rd_fwd = rd_oor ? '0 : mem[rd_idx];
    for (int k = 0; k < int'(NUM_LANES); k++) begin
      if (wr_hit && !rd_oor && (wr_idx == rd_idx) && wr_en_i[k]) begin
        rd_fwd[k*LANE_WIDTH +: LANE_WIDTH] = wr_data_i[k*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_comb begin
    rd_a_valid_d = rd_fire;
    rd_a_err_d   = rd_fire && rd_oor;
    rd_a_data_d  = rd_fire ? rd_fwd : rd_a_data_q;
    wr_err_d     = idle && (|wr_en_i) && wr_oor;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt_q    <= '0;
      rd_a_valid_q <= 1'b0;
      rd_a_err_q   <= 1'b0;
      rd_a_data_q  <= '0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      rd_a_valid_q <= rd_a_valid_d;
      rd_a_err_q   <= rd_a_err_d;
      rd_a_data_q  <= rd_a_data_d;
      wr_err_q     <= wr_err_d;
    end
  end

  // Storage is deliberately not reset; the sweep provides known contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < int'(NUM_LANES); k++) begin
        if (mem_lane_en[k]) begin
          mem[mem_idx][k*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata[k*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  rd_b_valid_q, rd_b_valid_d;
    logic                  rd_b_err_q, rd_b_err_d;
    logic [DATA_WIDTH-1:0] rd_b_data_q, rd_b_data_d;

    // Second stage keeps advancing during a sweep so in-flight reads finish.
    always_comb begin
      rd_b_valid_d = rd_a_valid_q;
      rd_b_err_d   = rd_a_err_q;
      rd_b_data_d  = rd_a_valid_q ? rd_a_data_q : rd_b_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_b_valid_q <= 1'b0;
        rd_b_err_q   <= 1'b0;
        rd_b_data_q  <= '0;
      end else begin
        rd_b_valid_q <= rd_b_valid_d;
        rd_b_err_q   <= rd_b_err_d;
        rd_b_data_q  <= rd_b_data_d;
      end
    end

    assign rd_data_o  = rd_b_data_q;
    assign rd_valid_o = rd_b_valid_q;
    assign rd_err_o   = rd_b_err_q;
  end else begin : g_no_out_reg
    assign rd_data_o  = rd_a_data_q;
    assign rd_valid_o = rd_a_valid_q;
    assign rd_err_o   = rd_a_err_q;
  end

  assign wr_err_o = wr_err_q;
  assign busy_o   = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_banked.sv
// Bench for ram_banked: one instance per read latency, shared directed stimulus,
// checked every cycle against a word-array model plus literal expectations.
module tb_ram_banked;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wr_en;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic        rd_en, clear;

  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, rd_err0, rd_err1, wr_err0, wr_err1, busy0, busy1;

  int checks = 0;
  int errors = 0;
  logic run_cmp = 1'b1;

  always #5 clk = ~clk;

  ram_banked #(.DEPTH_WORDS(D), .OUT_REG(0), .INIT_CLEAR(1)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data0), .rd_valid_o(rd_valid0),
    .rd_err_o(rd_err0), .wr_err_o(wr_err0), .clear_i(clear), .busy_o(busy0));

  ram_banked #(.DEPTH_WORDS(D), .OUT_REG(1), .INIT_CLEAR(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data1), .rd_valid_o(rd_valid1),
    .rd_err_o(rd_err1), .wr_err_o(wr_err1), .clear_i(clear), .busy_o(busy1));

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural model: array of words, sweep countdown, and the read results
  // each latency should present.
  logic [31:0] m_mem [D];
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_d0, m_d1, m_pd;
  logic        m_v0, m_e0, m_v1, m_e1, m_pv, m_pe, m_werr;

  always @(posedge clk) begin : model
    logic [31:0] r;
    logic        re;
    int          ri, wi;
    if (rst) begin
      m_busy = 1'b1; m_cnt = 0;
      m_d0 = '0; m_d1 = '0; m_pd = '0;
      m_v0 = 0; m_e0 = 0; m_v1 = 0; m_e1 = 0; m_pv = 0; m_pe = 0; m_werr = 0;
    end else begin
      m_v1 = m_pv; m_e1 = m_pe;
      if (m_pv) m_d1 = m_pd;
      m_pv = 0; m_pe = 0; m_v0 = 0; m_e0 = 0; m_werr = 0;
      if (m_busy) begin
        m_mem[m_cnt[3:0]] = '0;
        m_cnt++;
        if (m_cnt == D) m_busy = 1'b0;
      end else begin
        ri = int'(rd_addr / 32'd4);
        wi = int'(wr_addr / 32'd4);
        if (rd_en) begin
          if (rd_addr / 32'd4 >= 32'(D)) begin
            r = '0; re = 1'b1;
          end else begin
            r = m_mem[ri[3:0]]; re = 1'b0;
            if (wr_addr / 32'd4 == rd_addr / 32'd4)
              for (int k = 0; k < 4; k++) if (wr_en[k]) r[8*k +: 8] = wr_data[8*k +: 8];
          end
          m_v0 = 1; m_e0 = re; m_d0 = r;
          m_pv = 1; m_pe = re; m_pd = r;
        end
        if (wr_en != 4'h0) begin
          if (wr_addr / 32'd4 >= 32'(D)) m_werr = 1'b1;
          else for (int k = 0; k < 4; k++) if (wr_en[k]) m_mem[wi[3:0]][8*k +: 8] = wr_data[8*k +: 8];
        end
        if (clear) begin
          m_busy = 1'b1; m_cnt = 0;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      check("busy0", 32'(busy0), 32'(m_busy));
      check("busy1", 32'(busy1), 32'(m_busy));
      check("rd_valid0", 32'(rd_valid0), 32'(m_v0));
      check("rd_err0", 32'(rd_err0), 32'(m_e0));
      check("rd_data0", rd_data0, m_d0);
      check("rd_valid1", 32'(rd_valid1), 32'(m_v1));
      check("rd_err1", 32'(rd_err1), 32'(m_e1));
      check("rd_data1", rd_data1, m_d1);
      check("wr_err0", 32'(wr_err0), 32'(m_werr));
      check("wr_err1", 32'(wr_err1), 32'(m_werr));
    end
  end

  task automatic drive(input logic [3:0] we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic re, input logic [31:0] ra, input logic clr);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra; clear = clr;
  endtask

  task automatic idle_cycle();
    drive(4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Read (optionally alongside a write) and pin both latencies to a literal.
  task automatic rd_check(input string nm, input logic [31:0] ra, input logic [31:0] exp,
                          input logic exp_err, input logic [3:0] we, input logic [31:0] wd);
    drive(we, ra, wd, 1'b1, ra, 1'b0);
    idle_cycle();
    check({nm, "_lat1_valid"}, 32'(rd_valid0), 32'd1);
    check({nm, "_lat1_data"}, rd_data0, exp);
    check({nm, "_lat1_err"}, 32'(rd_err0), 32'(exp_err));
    check({nm, "_lat2_early"}, 32'(rd_valid1), 32'd0);
    @(negedge clk);
    check({nm, "_lat2_valid"}, 32'(rd_valid1), 32'd1);
    check({nm, "_lat2_data"}, rd_data1, exp);
    check({nm, "_lat2_err"}, 32'(rd_err1), 32'(exp_err));
  endtask

  task automatic release_and_count(input logic with_rd);
    int n;
    n = 0;
    @(negedge clk);
    rst = 1'b0; rd_en = with_rd; rd_addr = 32'h0;
    while (busy0 && n < 40) begin
      check("busy_no_valid0", 32'(rd_valid0), 32'd0);
      check("busy_no_valid1", 32'(rd_valid1), 32'd0);
      n++;
      @(negedge clk);
    end
    rd_en = 1'b0;
    check("busy_cycles", 32'(n), 32'd16);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] bb [3];
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_en = 0; rd_addr = '0; clear = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd1);
    check("rst_valid", 32'(rd_valid0), 32'd0);
    check("rst_data", rd_data0, 32'h0);
    check("rst_wr_err", 32'(wr_err1), 32'd0);

    release_and_count(1'b0);
    rd_check("cleared_3c", 32'h3C, 32'h0, 1'b0, 4'h0, 32'h0);

    // Lane-masked writes.
    drive(4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    drive(4'h1, 32'h10, 32'h000000AA, 1'b0, 32'h0, 1'b0);
    rd_check("lanes_10", 32'h10, 32'hDEADBEAA, 1'b0, 4'h0, 32'h0);

    // Same-cycle write and read of one word.
    drive(4'hF, 32'h20, 32'hAABBCCDD, 1'b0, 32'h0, 1'b0);
    rd_check("fwd_20", 32'h20, 32'hAA2233DD, 1'b0, 4'b0110, 32'h11223344);
    rd_check("after_fwd_20", 32'h20, 32'hAA2233DD, 1'b0, 4'h0, 32'h0);

    // Out-of-range write and read.
    drive(4'hF, 32'h00, 32'h01020304, 1'b0, 32'h0, 1'b0);
    drive(4'hF, 32'h40, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
    idle_cycle();
    check("oor_wr_err0", 32'(wr_err0), 32'd1);
    check("oor_wr_err1", 32'(wr_err1), 32'd1);
    @(negedge clk);
    check("oor_wr_err_pulse", 32'(wr_err0), 32'd0);
    rd_check("word0_kept", 32'h00, 32'h01020304, 1'b0, 4'h0, 32'h0);
    rd_check("oor_rd_40", 32'h40, 32'h0, 1'b1, 4'h0, 32'h0);

    // Fill, request clear with a concurrent read, then reset mid-sweep.
    for (int i = 0; i < D; i++) drive(4'hF, 32'(i * 4), 32'h5A5A5A5A, 1'b0, 32'h0, 1'b0);
    drive(4'h0, 32'h0, 32'h0, 1'b1, 32'h08, 1'b1);
    idle_cycle();
    check("clr_rd_valid0", 32'(rd_valid0), 32'd1);
    check("clr_rd_data0", rd_data0, 32'h5A5A5A5A);
    check("clr_busy", 32'(busy0), 32'd1);
    @(negedge clk);
    check("clr_rd_valid1", 32'(rd_valid1), 32'd1);
    check("clr_rd_data1", rd_data1, 32'h5A5A5A5A);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midsweep_rst_busy", 32'(busy0), 32'd1);
    release_and_count(1'b1);
    for (int i = 0; i < D; i++) rd_check("swept", 32'(i * 4), 32'h0, 1'b0, 4'h0, 32'h0);

    // Back-to-back reads.
    bb[0] = 32'h00000011; bb[1] = 32'h00002200; bb[2] = 32'h00330000;
    for (int i = 0; i < 3; i++) drive(4'hF, 32'(i * 4), bb[i], 1'b0, 32'h0, 1'b0);
    drive(4'h0, 32'h0, 32'h0, 1'b1, 32'h00, 1'b0);
    drive(4'h0, 32'h0, 32'h0, 1'b1, 32'h04, 1'b0);
    check("b2b0_lat1", rd_data0, bb[0]);
    drive(4'h0, 32'h0, 32'h0, 1'b1, 32'h08, 1'b0);
    check("b2b1_lat1", rd_data0, bb[1]);
    check("b2b0_lat2", rd_data1, bb[0]);
    idle_cycle();
    check("b2b2_lat1", rd_data0, bb[2]);
    check("b2b2_valid", 32'(rd_valid0), 32'd1);
    check("b2b1_lat2", rd_data1, bb[1]);
    @(negedge clk);
    check("b2b2_lat2", rd_data1, bb[2]);
    check("b2b_end_valid0", 32'(rd_valid0), 32'd0);
    @(negedge clk);
    check("b2b_end_valid1", 32'(rd_valid1), 32'd0);

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
